// File: rtl/xs_pkg.sv
// Shared types and helper functions for the xorshift collector.
// Holds the sample word type, the checksum step and a saturating increment.
package xs_pkg;

  typedef bit [63:0] xs_word_t;

  // One checksum step: rotate the accumulator left by one bit, then fold in the sample.
  function automatic xs_word_t rotl1_xor(xs_word_t acc, xs_word_t d);
    return {acc[62:0], acc[63]} ^ d;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(logic [63:0] v, int unsigned w);
    logic [63:0] max_val;
    max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_val) ? max_val : v + 64'd1;
  endfunction

endpackage

// File: rtl/xs_fifo.sv
// First-word fall-through circular FIFO with wrap-bit pointers and a one-cycle flush.
// Head data is read combinationally and forced to zero while the FIFO is empty.
module xs_fifo
  import xs_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  xs_word_t                   wr_data,
  output xs_word_t                   rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  xs_word_t      mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // The extra pointer bit toggles naturally on wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/xs_collector.sv
// Captures unthrottled xorshift samples into a FIFO, drains them over valid/ready,
// and keeps accepted-count, checksum, drop-count and zero-sample statistics.
module xs_collector
  import xs_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_vld,
  input  logic [63:0]                data,
  input  logic                       flush,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [63:0]                out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           count,
  output logic [63:0]                checksum,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       overflow,
  output logic                       zero_seen
);

  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;
  xs_word_t    head;

  logic [CNT_W-1:0]  count_reg;
  xs_word_t          checksum_reg;
  logic [DROP_W-1:0] drop_cnt_reg;
  logic              overflow_reg;
  logic              zero_seen_reg;

  // A pop at full frees the slot the incoming sample needs, so it is accepted.
  assign out_vld = !empty;
  assign pop     = out_vld && out_rdy;
  assign push    = data_vld && !flush && (!full || pop);
  assign drop    = data_vld && !flush && full && !pop;

  xs_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop && !flush),
    .flush   (flush),
    .wr_data (data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      checksum_reg  <= '0;
      drop_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
      zero_seen_reg <= 1'b0;
    end else begin
      if (push) begin
        count_reg     <= count_reg + 1'b1;
        checksum_reg  <= rotl1_xor(checksum_reg, data);
        zero_seen_reg <= zero_seen_reg | (data == 64'h0);
      end
      if (drop) begin
        drop_cnt_reg <= DROP_W'(sat_inc(64'(drop_cnt_reg), DROP_W));
        overflow_reg <= 1'b1;
      end
    end
  end

  assign out_data  = head;
  assign count     = count_reg;
  assign checksum  = checksum_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign overflow  = overflow_reg;
  assign zero_seen = zero_seen_reg;

endmodule

// File: tb/tb_xs_collector.sv
// Directed and scoreboard checks for xs_collector, plus a narrow-drop-counter instance
// used to observe drop counter saturation.
module tb_xs_collector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, data_vld, flush, out_rdy;
  logic [63:0] data;
  logic        out_vld, overflow, zero_seen;
  logic [63:0] out_data, checksum;
  logic [4:0]  level;
  logic [31:0] count;
  logic [15:0] drop_cnt;

  logic        rst2, data_vld2, flush2, out_rdy2;
  logic [63:0] data2;
  logic        out_vld2, overflow2, zero_seen2;
  logic [63:0] out_data2, checksum2;
  logic [4:0]  level2;
  logic [31:0] count2;
  logic [1:0]  drop_cnt2;

  xs_collector #(.DEPTH(16), .CNT_W(32), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .data_vld(data_vld), .data(data), .flush(flush),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .level(level),
    .count(count), .checksum(checksum), .drop_cnt(drop_cnt), .overflow(overflow),
    .zero_seen(zero_seen)
  );

  xs_collector #(.DEPTH(16), .CNT_W(32), .DROP_W(2)) dut2 (
    .clk(clk), .rst(rst2), .data_vld(data_vld2), .data(data2), .flush(flush2),
    .out_vld(out_vld2), .out_rdy(out_rdy2), .out_data(out_data2), .level(level2),
    .count(count2), .checksum(checksum2), .drop_cnt(drop_cnt2), .overflow(overflow2),
    .zero_seen(zero_seen2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; data_vld = 1'b0; flush = 1'b0; out_rdy = 1'b0; data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [63:0] v);
    data_vld = 1'b1; data = v;
    tick();
    data_vld = 1'b0;
  endtask

  logic [63:0] q[$];
  logic [63:0] cs_m;
  int          cnt_m;
  logic        pop_m, push_m, vld_r, rdy_r;
  logic [63:0] d_r;

  initial begin
    rst2 = 1'b1; data_vld2 = 1'b0; data2 = '0; flush2 = 1'b0; out_rdy2 = 1'b0;

    // 1. reset dominates a live strobe
    rst = 1'b1; data_vld = 1'b1; data = 64'h55; flush = 1'b0; out_rdy = 1'b0;
    tick(); tick();
    chk("rst out_vld", out_vld, 0);
    chk("rst out_data", out_data, 0);
    chk("rst level", level, 0);
    chk("rst count", count, 0);
    chk("rst checksum", checksum, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst overflow", overflow, 0);
    chk("rst zero_seen", zero_seen, 0);
    rst = 1'b0; data = 64'h1;
    tick();
    data_vld = 1'b0;
    chk("first out_vld", out_vld, 1);
    chk("first out_data", out_data, 64'h1);

    // 2. ordering and checksum: 1 -> 2 -> 0 -> 3
    do_reset();
    push_one(64'h1); push_one(64'h2); push_one(64'h3);
    chk("ord level", level, 3);
    chk("ord count", count, 3);
    chk("ord checksum", checksum, 64'h3);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("ord out_data[%0d]", i), out_data, i);
      out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    end
    chk("ord drained", out_vld, 0);

    // 3. overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 20; i++) push_one(64'd100 + i);
    chk("ovf level", level, 16);
    chk("ovf count", count, 16);
    chk("ovf drop_cnt", drop_cnt, 4);
    chk("ovf overflow", overflow, 1);
    tick();
    chk("ovf hold", out_data, 64'd100);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf drain[%0d]", i), out_data, 64'd100 + i);
      out_rdy = 1'b1; tick(); out_rdy = 1'b0;
    end
    chk("ovf empty", out_vld, 0);

    // 4. full with simultaneous pop accepts the sample
    do_reset();
    for (int i = 0; i < 16; i++) push_one(64'd200 + i);
    data_vld = 1'b1; data = 64'hABC; out_rdy = 1'b1;
    tick();
    data_vld = 1'b0; out_rdy = 1'b0;
    chk("fullpop level", level, 16);
    chk("fullpop drop_cnt", drop_cnt, 0);
    chk("fullpop count", count, 17);
    chk("fullpop head", out_data, 64'd201);

    // 5. flush discards contents and the concurrent sample
    do_reset();
    for (int i = 0; i < 5; i++) push_one(64'd300 + i);
    flush = 1'b1; data_vld = 1'b1; data = 64'h999; out_rdy = 1'b1;
    tick();
    flush = 1'b0; data_vld = 1'b0; out_rdy = 1'b0;
    chk("flush level", level, 0);
    chk("flush out_vld", out_vld, 0);
    chk("flush count", count, 5);
    chk("flush drop_cnt", drop_cnt, 0);
    chk("flush out_data", out_data, 0);

    // 6a. zero sample flag
    do_reset();
    push_one(64'h7);
    chk("zero before", zero_seen, 0);
    push_one(64'h0);
    chk("zero after", zero_seen, 1);

    // 6b. two-bit drop counter saturates at 3
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    for (int i = 0; i < 21; i++) begin
      data_vld2 = 1'b1; data2 = 64'd400 + i; tick();
    end
    data_vld2 = 1'b0;
    chk("sat drop_cnt", drop_cnt2, 3);
    chk("sat overflow", overflow2, 1);
    chk("sat level", level2, 16);

    // 6c. random traffic against a scoreboard queue
    do_reset();
    q.delete(); cs_m = '0; cnt_m = 0;
    for (int n = 0; n < 400; n++) begin
      chk("rnd out_vld", out_vld, (q.size() != 0));
      if (q.size() != 0) chk("rnd out_data", out_data, q[0]);
      vld_r = ($urandom_range(0, 3) != 0);
      rdy_r = ($urandom_range(0, 2) == 0);
      d_r   = {$urandom, $urandom};
      data_vld = vld_r; data = d_r; out_rdy = rdy_r;
      pop_m  = (q.size() != 0) && rdy_r;
      push_m = vld_r && ((q.size() != 16) || pop_m);
      tick();
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(d_r);
        cnt_m++;
        cs_m = {cs_m[62:0], cs_m[63]} ^ d_r;
      end
    end
    data_vld = 1'b0; out_rdy = 1'b0;
    chk("rnd level", level, q.size());
    chk("rnd count", count, cnt_m);
    chk("rnd checksum", checksum, cs_m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
